// File: rtl/mac_accum_pipe_if.sv
// rtl/mac_accum_pipe_if.sv - beat input and result output handshake bundle for mac_accum_pipe
interface mac_accum_pipe_if #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 24
);
    logic                  inValid;
    logic                  inReady;
    logic                  inLast;
    logic                  signedMode;
    logic [LANES*DW-1:0]   pixelsIn;
    logic [LANES*DW-1:0]   weightsIn;
    logic                  outValid;
    logic                  outReady;
    logic [ACC_W-1:0]      sumOut;
    logic                  overflow;

    // master drives beats and consumes results; slave is the engine
    modport master (
        output inValid, inLast, signedMode, pixelsIn, weightsIn, outReady,
        input  inReady, outValid, sumOut, overflow
    );

    modport slave (
        input  inValid, inLast, signedMode, pixelsIn, weightsIn, outReady,
        output inReady, outValid, sumOut, overflow
    );
endinterface

// File: rtl/mac_accum_pipe.sv
// rtl/mac_accum_pipe.sv - three-stage pipelined LANES-wide dot product with saturating vector accumulator
module mac_accum_pipe #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic            clk,
    input  logic            rst,
    mac_accum_pipe_if.slave bus
);
    localparam int PW = 2*DW + 1;
    localparam int SW = PW + $clog2(LANES);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Operands widened to the product width so one signed multiply covers both modes
    function automatic logic [PW-1:0] extendOp(input logic [DW-1:0] v, input logic sgn);
        return sgn ? {{(PW-DW){v[DW-1]}}, v} : {{(PW-DW){1'b0}}, v};
    endfunction

    logic            stall;

    logic [PW-1:0]   prodNext [LANES];
    logic [PW-1:0]   s1Prod   [LANES];
    logic            s1Valid;
    logic            s1Last;

    logic [SW-1:0]   sumNext;
    logic [SW-1:0]   s2Sum;
    logic            s2Valid;
    logic            s2Last;

    logic [ACC_W:0]   accExt;
    logic [ACC_W:0]   sumExt;
    logic [ACC_W:0]   total;
    logic             clampNow;
    logic [ACC_W-1:0] clamped;

    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [ACC_W-1:0] sumOutReg;
    logic             overflowReg;
    logic             outValidReg;

    assign stall       = outValidReg & ~bus.outReady;
    assign bus.inReady = ~stall;
    assign bus.outValid = outValidReg;
    assign bus.sumOut   = sumOutReg;
    assign bus.overflow = overflowReg;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prodNext[i] = PW'($signed(extendOp(bus.pixelsIn[i*DW +: DW], bus.signedMode)) *
                              $signed(extendOp(bus.weightsIn[i*DW +: DW], bus.signedMode)));
        end
    end

    always_comb begin
        sumNext = '0;
        for (int i = 0; i < LANES; i++) begin
            sumNext = sumNext + {{(SW-PW){s1Prod[i][PW-1]}}, s1Prod[i]};
        end
    end

    // One guard bit above the accumulator exposes overflow as a sign disagreement
    always_comb begin
        accExt   = {acc[ACC_W-1], acc};
        sumExt   = {{(ACC_W+1-SW){s2Sum[SW-1]}}, s2Sum};
        total    = accExt + sumExt;
        clampNow = total[ACC_W] ^ total[ACC_W-1];
        if (!clampNow) begin
            clamped = total[ACC_W-1:0];
        end else if (total[ACC_W]) begin
            clamped = ACC_MIN;
        end else begin
            clamped = ACC_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                s1Prod[i] <= '0;
            end
            s1Valid     <= 1'b0;
            s1Last      <= 1'b0;
            s2Sum       <= '0;
            s2Valid     <= 1'b0;
            s2Last      <= 1'b0;
            acc         <= '0;
            sticky      <= 1'b0;
            sumOutReg   <= '0;
            overflowReg <= 1'b0;
            outValidReg <= 1'b0;
        end else if (!stall) begin
            s1Valid <= bus.inValid;
            s1Last  <= bus.inLast;
            if (bus.inValid) begin
                for (int i = 0; i < LANES; i++) begin
                    s1Prod[i] <= prodNext[i];
                end
            end

            s2Valid <= s1Valid;
            s2Last  <= s1Last;
            if (s1Valid) begin
                s2Sum <= sumNext;
            end

            // Not stalled means the output register is empty or being taken this edge
            outValidReg <= s2Valid & s2Last;
            if (s2Valid) begin
                if (s2Last) begin
                    sumOutReg   <= clamped;
                    overflowReg <= sticky | clampNow;
                    acc         <= '0;
                    sticky      <= 1'b0;
                end else begin
                    acc    <= clamped;
                    sticky <= sticky | clampNow;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accum_pipe.sv
// tb/tb_mac_accum_pipe.sv - scoreboard bench for mac_accum_pipe with directed and random vectors
module tb_mac_accum_pipe;
    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int VW    = LANES*DW;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    mac_accum_pipe_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus ();

    mac_accum_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    longint expSum[$];
    bit     expOvf[$];
    longint modelAcc = 0;
    bit     modelSticky = 1'b0;
    longint lastSum = 0;
    bit     lastOvf = 1'b0;
    bit     randReady = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint dotProd(input logic [VW-1:0] pix, input logic [VW-1:0] wts, input logic sgn);
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            logic [DW-1:0] pa;
            logic [DW-1:0] pw;
            longint a;
            longint w;
            pa = pix[i*DW +: DW];
            pw = wts[i*DW +: DW];
            a = sgn ? longint'($signed(pa)) : longint'(pa);
            w = sgn ? longint'($signed(pw)) : longint'(pw);
            s += a * w;
        end
        return s;
    endfunction

    task automatic modelBeat(input logic [VW-1:0] pix, input logic [VW-1:0] wts, input logic last, input logic sgn);
        longint t = modelAcc + dotProd(pix, wts, sgn);
        bit c = 1'b0;
        if (t > MAXV) begin
            t = MAXV;
            c = 1'b1;
        end else if (t < MINV) begin
            t = MINV;
            c = 1'b1;
        end
        if (last) begin
            expSum.push_back(t);
            expOvf.push_back(modelSticky | c);
            modelAcc    = 0;
            modelSticky = 1'b0;
        end else begin
            modelAcc    = t;
            modelSticky = modelSticky | c;
        end
    endtask

    function automatic logic [VW-1:0] lane(input int idx, input logic [DW-1:0] v);
        logic [VW-1:0] r = '0;
        r[idx*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i*DW +: DW] = DW'($urandom);
        end
        return r;
    endfunction

    // Caller is just after a rising edge; returns just after the accepting edge
    task automatic sendBeat(input logic [VW-1:0] pix, input logic [VW-1:0] wts, input logic last, input logic sgn);
        int n = 0;
        bit ok = 1'b0;
        bus.inValid    = 1'b1;
        bus.pixelsIn   = pix;
        bus.weightsIn  = wts;
        bus.inLast     = last;
        bus.signedMode = sgn;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (bus.inReady) begin
                ok = 1'b1;
                modelBeat(pix, wts, last, sgn);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL beat_accept_timeout: got inReady=0 for %0d cycles expected acceptance", n);
        end
        bus.inValid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (expSum.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expSum.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: got %0d results pending expected 0", nm, expSum.size());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.outValid && bus.outReady) begin
                longint act;
                act = longint'($signed(bus.sumOut));
                lastSum = act;
                lastOvf = bus.overflow;
                if (expSum.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got sum %0d expected no result pending", act);
                end else begin
                    longint e;
                    bit eo;
                    e  = expSum.pop_front();
                    eo = expOvf.pop_front();
                    check("result_sum", act, e);
                    check("result_ovf", longint'(bus.overflow), longint'(eo));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) begin
                bus.outReady = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        bus.inValid    = 1'b0;
        bus.inLast     = 1'b0;
        bus.signedMode = 1'b0;
        bus.pixelsIn   = '0;
        bus.weightsIn  = '0;
        bus.outReady   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outValid", longint'(bus.outValid), 0);
        check("reset_sumOut", longint'(bus.sumOut), 0);
        check("reset_overflow", longint'(bus.overflow), 0);
        check("reset_inReady", longint'(bus.inReady), 1);
        @(posedge clk);
        #1;

        sendBeat(lane(0, 8'h56) | lane(13, 8'h37), lane(0, 8'h32) | lane(13, 8'h48), 1'b1, 1'b0);
        drain("t1");
        check("t1_sum", lastSum, 8260);
        check("t1_ovf", longint'(lastOvf), 0);

        for (int b = 0; b < 3; b++) begin
            sendBeat(lane(0, 8'h12), lane(0, 8'h34), b == 2, 1'b0);
        end
        drain("t2");
        check("t2_sum", lastSum, 2808);

        sendBeat(lane(0, 8'hFF) | lane(1, 8'h80), lane(0, 8'h02) | lane(1, 8'h01), 1'b1, 1'b1);
        drain("t3s");
        check("t3_signed_sum", lastSum, -130);
        sendBeat(lane(0, 8'hFF) | lane(1, 8'h80), lane(0, 8'h02) | lane(1, 8'h01), 1'b1, 1'b0);
        drain("t3u");
        check("t3_unsigned_sum", lastSum, 638);

        for (int b = 0; b < 32; b++) begin
            sendBeat({LANES{8'h80}}, {LANES{8'h80}}, b == 31, 1'b1);
        end
        drain("t4a");
        check("t4_sat_sum", lastSum, 8388607);
        check("t4_sat_ovf", longint'(lastOvf), 1);
        sendBeat(lane(0, 8'h01), lane(0, 8'h01), 1'b1, 1'b1);
        drain("t4b");
        check("t4_after_sum", lastSum, 1);
        check("t4_after_ovf", longint'(lastOvf), 0);

        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sendBeat(lane(0, DW'(i + 1)), lane(0, 8'h03), 1'b1, 1'b0);
        end
        fork
            sendBeat(lane(0, 8'h04), lane(0, 8'h03), 1'b1, 1'b0);
        join_none
        repeat (4) begin
            @(negedge clk);
            check("t5_inReady_low", longint'(bus.inReady), 0);
            check("t5_outValid_held", longint'(bus.outValid), 1);
            check("t5_sum_hold", longint'($signed(bus.sumOut)), 3);
        end
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        drain("t5");
        check("t5_last_sum", lastSum, 12);

        sendBeat(lane(0, 8'h10), lane(0, 8'h10), 1'b0, 1'b0);
        sendBeat(lane(0, 8'h10), lane(0, 8'h10), 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("t6_rst_outValid", longint'(bus.outValid), 0);
        check("t6_rst_sumOut", longint'(bus.sumOut), 0);
        check("t6_rst_overflow", longint'(bus.overflow), 0);
        modelAcc    = 0;
        modelSticky = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_inReady", longint'(bus.inReady), 1);
        @(posedge clk);
        #1;
        sendBeat(lane(0, 8'h02), lane(0, 8'h03), 1'b1, 1'b0);
        drain("t6");
        check("t6_sum", lastSum, 6);

        randReady = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int  len;
            logic sgn;
            len = $urandom_range(1, 4);
            sgn = logic'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
                sendBeat(randVec(), randVec(), b == len - 1, sgn);
            end
        end
        randReady = 1'b0;
        @(posedge clk);
        #1;
        bus.outReady = 1'b1;
        drain("random");

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
